dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter_rr_arb2.sv | 15 +
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared SoC data-memory package: memory geometry, word/byte-enable types,
// the arbiter state encoding and the request record used on each port.
// Imported by the arbiter, its interface and the data memory.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_DEPTH = 28672;   // data memory size in words
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BE_W       = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BE_W-1:0]   be_t;

  typedef enum logic {
    ST_RR    = 1'b0,   // round-robin between A and B
    ST_LOCKB = 1'b1    // port B owns the memory
  } arb_state_e;

  typedef struct packed {
    word_t addr;    // byte address
    be_t   wen;     // 0 = read
    word_t wdata;
  } dmem_req_t;

  // Byte address maps to a word that exists in the memory.
  function automatic logic in_range(input word_t addr, input int unsigned depth);
    return {2'b00, addr[WORD_W-1:2]} < depth;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (A = CPU data, B = loader/DMA),
// the arbiter and the data memory.
//   slave  : the arbiter side (takes requests + mem_rdata, drives the rest)
//   master : the requester/memory side
interface dmem_arbiter_if;
  logic                          a_req,   b_req,   b_lock;
  dmem_arbiter_pkg::word_t       a_addr,  b_addr;
  dmem_arbiter_pkg::be_t         a_wen,   b_wen;
  dmem_arbiter_pkg::word_t       a_wdata, b_wdata;
  logic                          a_gnt,   b_gnt;
  logic                          a_rvalid, b_rvalid, err;
  dmem_arbiter_pkg::word_t       rdata;
  dmem_arbiter_pkg::word_t       mem_addr;
  dmem_arbiter_pkg::be_t         mem_wenable;
  dmem_arbiter_pkg::word_t       mem_wdata, mem_rdata;

  modport slave (
    input  a_req, b_req, b_lock, a_addr, b_addr, a_wen, b_wen, a_wdata, b_wdata,
           mem_rdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, err, rdata,
           mem_addr, mem_wenable, mem_wdata
  );

  modport master (
    output a_req, b_req, b_lock, a_addr, b_addr, a_wen, b_wen, a_wdata, b_wdata,
           mem_rdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, err, rdata,
           mem_addr, mem_wenable, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin priority select (purely combinational).
//   req_i  : [0] = port A, [1] = port B
//   last_i : 1 when port B was granted most recently
//   gnt_o  : one-hot grant, or 0 when nobody requests
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    // Conflict goes to whichever port did not win last time.
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between port A (CPU) and
// port B (loader/DMA). Grants are combinational, responses arrive exactly one
// cycle later on the granted port. Port B may lock the memory for up to
// LOCK_MAX consecutive cycles; a lock that runs out hands the next grant to A.
//   clock, resetn : clock, synchronous active-low reset
//   bus (slave)   : requests/grants/responses of both ports + memory side
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH    = DMEM_DEPTH,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clock,
  input  logic          resetn,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state_q, state_d;
  logic             last_b_q, last_b_d;   // B granted most recently
  logic [CNT_W-1:0] cnt_q, cnt_d;         // cycles spent in LOCKB
  logic             a_owed_q, a_owed_d;   // lock was cut short; A goes next
  word_t            addr_q;               // last presented word address
  logic [1:0]       rvalid_q;             // [0] = A, [1] = B
  logic             err_q, rd_ok_q;

  dmem_req_t [1:0]  req;
  dmem_req_t        sel;
  logic [1:0]       req_v, arb_req, gnt;
  logic             any_gnt, hit;
  word_t            word_addr;

  assign req[0] = '{addr: bus.a_addr, wen: bus.a_wen, wdata: bus.a_wdata};
  assign req[1] = '{addr: bus.b_addr, wen: bus.b_wen, wdata: bus.b_wdata};

  // No grants at all while reset is held.
  assign req_v   = {bus.b_req, bus.a_req} & {2{resetn}};
  assign arb_req = (state_q == ST_LOCKB) ? {req_v[1], 1'b0} : req_v;

  rr_arb2 u_rr (
    .req_i  (arb_req),
    .last_i (last_b_q),
    .gnt_o  (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel       = req[gnt[1]];
  assign word_addr = {2'b00, sel.addr[WORD_W-1:2]};
  assign hit       = any_gnt && in_range(sel.addr, DEPTH);

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    a_owed_d = a_owed_q;
    if (any_gnt) last_b_d = gnt[1];
    if (gnt[0])  a_owed_d = 1'b0;
    case (state_q)
      ST_RR: begin
        // A lock request is ignored while A is still owed its turn.
        if (gnt[1] && bus.b_lock && !a_owed_q) begin
          state_d = ST_LOCKB;
          cnt_d   = '0;
        end
      end
      ST_LOCKB: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.b_lock) begin
          state_d = ST_RR;
        end else if (cnt_d == CNT_W'(LOCK_MAX)) begin
          state_d  = ST_RR;
          a_owed_d = 1'b1;
        end
      end
      default: state_d = ST_RR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_RR;
      last_b_q <= 1'b1;
      cnt_q    <= '0;
      a_owed_q <= 1'b0;
      addr_q   <= '0;
      rvalid_q <= '0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      a_owed_q <= a_owed_d;
      if (hit) addr_q <= word_addr;
      rvalid_q <= gnt;
      err_q    <= any_gnt && !hit;
      rd_ok_q  <= hit && (sel.wen == '0);
    end
  end

  assign bus.a_gnt       = gnt[0];
  assign bus.b_gnt       = gnt[1];
  // Responses are masked during reset so a grant in flight is dropped.
  assign bus.a_rvalid    = rvalid_q[0] & resetn;
  assign bus.b_rvalid    = rvalid_q[1] & resetn;
  assign bus.err         = err_q & resetn;
  assign bus.rdata       = (rd_ok_q && resetn) ? bus.mem_rdata : '0;
  // Address holds while idle so the memory keeps returning the same word.
  assign bus.mem_addr    = hit ? word_addr : addr_q;
  assign bus.mem_wenable = hit ? sel.wen : '0;
  assign bus.mem_wdata   = sel.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned DEPTH    = DMEM_DEPTH;
  localparam int          LOCK_MAX = 16;
  localparam logic [31:0] OOR      = 32'(4 * DMEM_DEPTH);

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clock  (clk),
    .resetn (rstn),
    .bus    (bus)
  );

  function automatic logic [31:0] pat(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous data memory: one-cycle read latency, byte-lane writes.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pat(32'(i));
      bus.mem_rdata <= '0;
    end else if (bus.mem_addr < DEPTH) begin
      for (int k = 0; k < 4; k++)
        if (bus.mem_wenable[k]) mem[bus.mem_addr[14:0]][k*8 +: 8] <= bus.mem_wdata[k*8 +: 8];
      bus.mem_rdata <= mem[bus.mem_addr[14:0]];
    end else begin
      bus.mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the memory and what each response must carry.
  bit          m_last_b, m_locked, m_owed;
  int          m_age;
  logic [1:0]  p_rv;
  logic        p_err;
  logic [31:0] p_rdata;
  logic [31:0] gm [DEPTH];

  logic [1:0]  s_gnt, s_rv;
  logic [3:0]  s_wen;
  logic        s_err;
  logic [31:0] s_rdata;

  // One clock: sample/check at negedge, advance the model, return after posedge.
  task automatic cyc();
    logic [1:0]  eg;
    logic [31:0] ad, wd, old;
    logic [3:0]  we;
    logic        inr;
    int unsigned wi;
    @(negedge clk);
    s_gnt   = {bus.b_gnt, bus.a_gnt};
    s_rv    = {bus.b_rvalid, bus.a_rvalid};
    s_wen   = bus.mem_wenable;
    s_err   = bus.err;
    s_rdata = bus.rdata;

    chk("rvalid", 32'(s_rv), rstn ? 32'(p_rv) : 32'd0);
    if (rstn && p_rv != 2'b00) begin
      chk("err", 32'(s_err), 32'(p_err));
      chk("rdata", s_rdata, p_rdata);
    end

    if (!rstn)                        eg = 2'b00;
    else if (m_locked)                eg = {bus.b_req, 1'b0};
    else if (bus.a_req && bus.b_req)  eg = m_last_b ? 2'b01 : 2'b10;
    else                              eg = {bus.b_req, bus.a_req};
    chk("gnt", 32'(s_gnt), 32'(eg));

    p_rv = eg; p_err = 1'b0; p_rdata = '0;
    if (eg != 2'b00) begin
      ad  = eg[1] ? bus.b_addr  : bus.a_addr;
      we  = eg[1] ? bus.b_wen   : bus.a_wen;
      wd  = eg[1] ? bus.b_wdata : bus.a_wdata;
      inr = (longint'(ad) / 4) < longint'(DEPTH);
      wi  = ad / 4;
      chk("mem_wen", 32'(s_wen), inr ? 32'(we) : 32'd0);
      if (inr) begin
        chk("mem_addr", bus.mem_addr, 32'(wi));
        if (we != 4'b0) chk("mem_wdata", bus.mem_wdata, wd);
        old = gm[wi];
        for (int k = 0; k < 4; k++) if (we[k]) gm[wi][k*8 +: 8] = wd[k*8 +: 8];
        p_rdata = (we == 4'b0) ? old : 32'd0;
      end
      p_err = !inr;
    end else begin
      chk("mem_wen_idle", 32'(s_wen), 32'd0);
    end

    if (!rstn) begin
      m_locked = 0; m_last_b = 1; m_age = 0; m_owed = 0; p_rv = 2'b00;
      for (int i = 0; i < int'(DEPTH); i++) gm[i] = pat(32'(i));
    end else begin
      if (m_locked) begin
        m_age++;
        if (!bus.b_lock) m_locked = 0;
        else if (m_age >= LOCK_MAX) begin m_locked = 0; m_owed = 1; end
      end else if (eg[1] && bus.b_lock && !m_owed) begin
        m_locked = 1; m_age = 0;
      end
      if (eg[0]) m_owed = 0;
      if (eg != 2'b00) m_last_b = eg[1];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_req = 0; bus.b_req = 0; bus.b_lock = 0;
    bus.a_wen = '0; bus.b_wen = '0;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return OOR + 32'($urandom_range(0, 64));
      1:       return 32'hFFFF_FFFC;
      2:       return 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    logic        a_req, b_req;
    logic [31:0] a_addr, b_addr;
    logic [3:0]  a_wen, b_wen;
    logic [1:0]  exp_gnt;
    logic [3:0]  exp_wen;
  } vec_t;

  function automatic vec_t mk(input logic ar, input logic br, input logic [31:0] aa,
                              input logic [31:0] ba, input logic [3:0] aw, input logic [3:0] bw,
                              input logic [1:0] eg, input logic [3:0] ew);
    vec_t v;
    v.a_req = ar; v.b_req = br; v.a_addr = aa; v.b_addr = ba;
    v.a_wen = aw; v.b_wen = bw; v.exp_gnt = eg; v.exp_wen = ew;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    int starved, a_gnts;
    bit a_done, lock_mode;

    // Starting from last-granted = B, no lock.
    tbl[0] = mk(1'b1, 1'b0, 32'h10, 32'h0,  4'h0, 4'h0, 2'b01, 4'h0);
    tbl[1] = mk(1'b1, 1'b1, 32'h20, 32'h24, 4'h0, 4'h0, 2'b10, 4'h0);
    tbl[2] = mk(1'b1, 1'b1, 32'h20, 32'h24, 4'h0, 4'h0, 2'b01, 4'h0);
    tbl[3] = mk(1'b0, 1'b0, 32'h0,  32'h0,  4'h0, 4'h0, 2'b00, 4'h0);
    tbl[4] = mk(1'b1, 1'b1, 32'h30, 32'h34, 4'h0, 4'h0, 2'b10, 4'h0);
    tbl[5] = mk(1'b0, 1'b1, 32'h0,  32'h40, 4'h0, 4'hF, 2'b10, 4'hF);
    tbl[6] = mk(1'b1, 1'b0, OOR,    32'h0,  4'hF, 4'h0, 2'b01, 4'h0);
    tbl[7] = mk(1'b1, 1'b1, OOR,    32'h44, 4'hF, 4'h3, 2'b10, 4'h3);
    tbl[8] = mk(1'b1, 1'b1, 32'h48, 32'h4C, 4'h8, 4'h1, 2'b01, 4'h8);
    tbl[9] = mk(1'b0, 1'b1, 32'h0,  32'h50, 4'h0, 4'h0, 2'b10, 4'h0);

    rstn = 0; idle();
    bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
    repeat (3) cyc();

    // Both read at reset release: A first, then B, each with its word.
    rstn = 1;
    bus.a_req = 1; bus.a_addr = 32'h200;
    bus.b_req = 1; bus.b_addr = 32'h304;
    cyc();
    chk("rel_first_gnt", 32'(s_gnt), 32'd1);
    bus.a_req = 0;
    cyc();
    chk("rel_second_gnt", 32'(s_gnt), 32'd2);
    chk("rel_a_rvalid", 32'(s_rv), 32'd1);
    chk("rel_a_rdata", s_rdata, pat(32'h80));
    bus.b_req = 0;
    cyc();
    chk("rel_b_rvalid", 32'(s_rv), 32'd2);
    chk("rel_b_rdata", s_rdata, pat(32'hC1));

    // Single-cycle table.
    foreach (tbl[i]) begin
      bus.a_req = tbl[i].a_req;   bus.b_req = tbl[i].b_req;   bus.b_lock = 0;
      bus.a_addr = tbl[i].a_addr; bus.b_addr = tbl[i].b_addr;
      bus.a_wen = tbl[i].a_wen;   bus.b_wen = tbl[i].b_wen;
      bus.a_wdata = $urandom;     bus.b_wdata = $urandom;
      cyc();
      chk("tbl_gnt", 32'(s_gnt), 32'(tbl[i].exp_gnt));
      chk("tbl_wen", 32'(s_wen), 32'(tbl[i].exp_wen));
    end
    idle();
    cyc();

    // Byte-lane write from B, read back by A.
    bus.b_req = 1; bus.b_addr = 32'h100; bus.b_wen = 4'b0010; bus.b_wdata = 32'hAABB_CCDD;
    cyc();
    chk("bw_b_gnt", 32'(s_gnt), 32'd2);
    chk("bw_wen", 32'(s_wen), 32'h2);
    idle();
    bus.a_req = 1; bus.a_addr = 32'h100;
    cyc();
    bus.a_req = 0;
    cyc();
    chk("bw_rvalid", 32'(s_rv), 32'd1);
    chk("bw_rdata", s_rdata, (pat(32'h40) & 32'hFFFF_00FF) | 32'h0000_CC00);

    // B locks for 20 cycles; A asks from the second cycle on.
    starved = 0; a_gnts = 0; a_done = 0;
    for (int c = 0; c < 20; c++) begin
      bus.b_req = 1; bus.b_lock = 1; bus.b_addr = 32'h400 + 32'(4 * c); bus.b_wen = '0;
      bus.a_req = (c >= 1) && !a_done; bus.a_addr = 32'h500; bus.a_wen = '0;
      cyc();
      if (bus.a_req && !s_gnt[0]) starved++;
      if (s_gnt[0]) begin a_gnts++; a_done = 1; end
    end
    chk("lock_starved", 32'(starved), 32'd16);
    chk("lock_a_gnts", 32'(a_gnts), 32'd1);
    idle();
    repeat (2) cyc();

    // Read exactly one word past the end.
    bus.a_req = 1; bus.a_addr = OOR; bus.a_wen = '0;
    cyc();
    chk("oor_gnt", 32'(s_gnt), 32'd1);
    chk("oor_wen", 32'(s_wen), 32'd0);
    bus.a_req = 0;
    cyc();
    chk("oor_rvalid", 32'(s_rv), 32'd1);
    chk("oor_err", 32'(s_err), 32'd1);
    chk("oor_rdata", s_rdata, 32'd0);

    // Reset in the middle of a burst.
    for (int c = 0; c < 4; c++) begin
      bus.a_req = 1; bus.a_addr = 32'(4 * $urandom_range(0, 63));
      bus.b_req = 1; bus.b_addr = 32'(4 * $urandom_range(0, 63));
      cyc();
    end
    rstn = 0;
    repeat (2) begin
      cyc();
      chk("rst_gnt", 32'(s_gnt), 32'd0);
      chk("rst_wen", 32'(s_wen), 32'd0);
      chk("rst_rvalid", 32'(s_rv), 32'd0);
    end
    rstn = 1;
    cyc();
    chk("rst_first_gnt", 32'(s_gnt), 32'd1);
    chk("rst_no_rvalid", 32'(s_rv), 32'd0);
    idle();
    cyc();

    // Random traffic against the model.
    lock_mode = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) lock_mode = !lock_mode;
      bus.a_req  = $urandom_range(0, 3) != 0;
      bus.b_req  = $urandom_range(0, 3) != 0;
      bus.b_lock = lock_mode;
      bus.a_addr = rnd_addr(); bus.b_addr = rnd_addr();
      bus.a_wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus.b_wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      bus.a_wdata = $urandom; bus.b_wdata = $urandom;
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
